mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter and sequencer for the dual-port distributed data memory: write port `a`/`d`/`we`, asynchronous read port `dpra`/`dpo`, 1024 × 32 bit. It serialises word accesses from the host loader (requester 0) and the CPU load/store unit (requester 1) onto the single memory and drives all memory-side address, data and enable signals. Each accepted access is latched, executed in one memory cycle and acknowledged with a done pulse. Read data is returned registered.

## Interface
- `ADDR_W`, default 10: memory word-address width; the memory depth is 2^ADDR_W.
- `DATA_W`, default 32: memory word width.
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req0`, `req1`, in, 1: access request from requester 0 / requester 1.
- `we0`, `we1`, in, 1: 1 = write, 0 = read; sampled with the request.
- `addr0`, `addr1`, in, ADDR_W: word address.
- `wdata0`, `wdata1`, in, DATA_W: write data.
- `gnt0`, `gnt1`, out, 1: one-cycle pulse; the request has been accepted.
- `done0`, `done1`, out, 1: one-cycle pulse; the access is complete.
- `rdata`, out, DATA_W: read data of the last completed read; shared by both requesters.
- `mem_a`, out, ADDR_W: memory write address.
- `mem_d`, out, DATA_W: memory write data.
- `mem_we`, out, 1: memory write enable.
- `mem_dpra`, out, ADDR_W: memory read address.
- `mem_dpo`, in, DATA_W: memory asynchronous read data.

## Operation
- Three-state FSM; reset state is IDLE.
  - IDLE: on a rising edge with any `req` high, pick a winner, latch its `we`/`addr`/`wdata` into `lat_*`, record it in `owner`, and go to ACCESS. With no request, stay in IDLE.
  - ACCESS: always go to DONE on the next edge. On that same edge the memory commits the write if `lat_we`=1. If `lat_we`=0, `rdata` <= `mem_dpo`.
  - DONE: always go to IDLE on the next edge.
- `gnt[owner]` is high only during ACCESS. `done[owner]` is high only during DONE. At most one `gnt` and one `done` are high at any time.
- Memory-side outputs:
  - `mem_a` = `mem_dpra` = `lat_addr`.
  - `mem_d` = `lat_wdata`.
  - `mem_we` = (state==ACCESS) & `lat_we`, decoded combinationally from the registered state.
- Requester rule: hold `req`, `we`, `addr` and `wdata` stable until `gnt` is seen. After `gnt`, the requester may change them. A `req` still high in DONE or IDLE is treated as a new request.
- `rdata` changes only on the ACCESS->DONE edge of a read. It holds across writes and idle cycles.
- Arbitration, round-robin: when both requests are high, the requester other than `last_owner` wins. `last_owner` updates on each IDLE->ACCESS edge and resets to 1, so requester 0 wins the first tie.
- With a single request, that requester wins regardless of `last_owner`.

## Timing
- Reset values: state IDLE; `gnt0`, `gnt1`, `done0`, `done1`, `mem_we` = 0; `rdata`, `lat_addr`, `lat_wdata`, `mem_a`, `mem_d`, `mem_dpra` = 0; `last_owner` = 1.
- Latency: request sampled at edge N, `gnt` in cycle N+1, `done` and valid `rdata` in cycle N+2.
- Throughput: one access per 3 cycles, back-to-back, with no idle bubble when `req` is held.
- Reset asserted during ACCESS: `mem_we` drops immediately, so no write is committed at the next edge. Outputs return to reset values asynchronously, and the in-flight access is lost with no `done`.
- Requests arriving in ACCESS or DONE are not sampled. They are arbitrated at the first IDLE edge.
- Address is full-width; no wrap or range check. Address 2^ADDR_W-1 is valid.
- A read issued to the address just written sees the new data, because the write committed before the read's ACCESS cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration as above.
- `MEM_ARB_RR_EN` not defined: fixed priority. Requester 0 always wins a tie, and `last_owner` is not implemented. All other behaviour is unchanged.

## Test plan
- Reset, then `req0`=1, `we0`=1, `addr0`=10'h005, `wdata0`=32'hDEADBEEF -> `gnt0` in the next cycle with `mem_we`=1, `mem_a`=5, `mem_d`=DEADBEEF; `done0` one cycle later.
- After the above, `req1` read `addr1`=5 -> `gnt1` then `done1`, with `rdata`=32'hDEADBEEF in the `done1` cycle.
- Both requests held continuously after reset -> grant order 0,1,0,1 every 3 cycles with RR; with `MEM_ARB_RR_EN` undefined -> 0,0,0.
- Write to 10'h3FF, then read 10'h3FF -> `rdata` equals the written value; no wrap to 0.
- `rst_n` pulsed low during ACCESS of a write of 32'h12345678 to addr 7 -> `mem_we` low immediately, no `done`; a later read of addr 7 returns the prior content.
- Read completes with `rdata`=X, followed by a write -> `rdata` still equals X after the write's `done`.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles the two requester handshakes and the memory-side bus of the data
// memory arbiter.
//
// Signals:
//   req0/req1      access request from requester 0 (host loader) / 1 (CPU LSU)
//   we0/we1        1 = write, 0 = read, sampled with the request
//   addr0/addr1    word address
//   wdata0/wdata1  write data
//   gnt0/gnt1      one-cycle pulse, request accepted
//   done0/done1    one-cycle pulse, access complete
//   rdata          read data of the last completed read (shared)
//   mem_a/mem_d/mem_we  memory write port
//   mem_dpra       memory asynchronous read address
//   mem_dpo        memory asynchronous read data
//
// Modports:
//   slave   arbiter side
//   master  requester side
//   mem     memory side
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_dpra;
    logic [DATA_W-1:0] mem_dpo;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dpo,
        output gnt0, gnt1, done0, done1, rdata,
        output mem_a, mem_d, mem_we, mem_dpra
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, done0, done1, rdata
    );

    modport mem (
        input  mem_a, mem_d, mem_we, mem_dpra,
        output mem_dpo
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Two-requester arbiter/sequencer for the 2^ADDR_W x DATA_W dual-port
// distributed data memory (write port a/d/we, async read port dpra/dpo).
// Each accepted access is latched, executed in one memory cycle and then
// acknowledged with a done pulse; read data is returned registered.
//
// Sequence per access: IDLE (sample/arbitrate) -> ACCESS (gnt, memory
// cycle) -> DONE (done pulse) -> IDLE. One access every 3 cycles.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_port_arbiter_if.slave: requester handshakes, rdata and the
//          memory-side address/data/enable signals
//
// Configuration:
//   MEM_ARB_RR_EN defined     round-robin on ties (other than last owner wins)
//   MEM_ARB_RR_EN undefined   fixed priority, requester 0 wins every tie
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic              owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              done0_q;
    logic              done1_q;
    logic              win1;

`ifdef MEM_ARB_RR_EN
    logic              last_owner;

    // On a tie the requester that did not win last time takes the port.
    assign win1 = bus.req1 & (~bus.req0 | ~last_owner);
`else
    assign win1 = bus.req1 & ~bus.req0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    if (bus.req0 | bus.req1) begin
                        owner     <= win1;
                        lat_we    <= win1 ? bus.we1    : bus.we0;
                        lat_addr  <= win1 ? bus.addr1  : bus.addr0;
                        lat_wdata <= win1 ? bus.wdata1 : bus.wdata0;
                        gnt0_q    <= ~win1;
                        gnt1_q    <= win1;
`ifdef MEM_ARB_RR_EN
                        last_owner <= win1;
`endif
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The memory commits a write on this same edge; a read
                    // captures the asynchronous read port.
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    done0_q <= ~owner;
                    done1_q <= owner;
                    if (!lat_we) begin
                        rdata_q <= bus.mem_dpo;
                    end
                    state   <= DONE;
                end
                DONE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_a    = lat_addr;
    assign bus.mem_dpra = lat_addr;
    assign bus.mem_d    = lat_wdata;
    // Decoded from the registered state so an asynchronous reset in ACCESS
    // removes the write enable before the next edge.
    assign bus.mem_we   = (state == ACCESS) & lat_we;

endmodule
